// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// slave is the stage's view of the bundle; master is the view of whatever surrounds it.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: MAIN drives the outputs and SKID catches the one beat in flight on a stall.
// in_ready and out_valid are registered, so neither handshake input reaches an output combinationally.
module pipe_stage_skid #(
  parameter int                DATA_W   = 160,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_skid_if.slave      bus,
  output logic [1:0]            occupancy,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_ready_q, out_valid_q;
  logic [15:0]       stall_q, stall_d;
  logic              accept, retire;

  assign accept = bus.in_valid  && in_ready_q;
  assign retire = out_valid_q   && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // flush overrides any handshake on this edge
      state_d     = EMPTY;
      main_ctrl_d = CTRL_RST;
      skid_ctrl_d = CTRL_RST;
      main_data_d = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d     = ONE;
          main_ctrl_d = bus.in_ctrl;
          main_data_d = bus.in_data;
        end
        ONE: begin
          if (accept && retire) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (retire) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !bus.out_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= CTRL_RST;
      skid_ctrl_q <= CTRL_RST;
      main_data_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = out_valid_q ? main_ctrl_q : CTRL_RST;
  assign bus.out_data  = main_data_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;

endmodule
